dec8b10b_wrap: RTL and testbench

Receive-side 8b/10b decoder wrapper for the e-link data path: accepts 10-bit symbols from the deserializer, decodes them to 8-bit bytes with running-disparity checking, and classifies each symbol as data, SOP, EOP or comma. It sits between the GBTX e-link deserializer and the downstream RX FIFO, acting as the counterpart of `enc8b10b_wrap` and emitting the same 2-bit `dataCode` encoding. Output is gated by a comma-based lock state machine and a frame tracker, so only in-frame payload and frame delimiters reach the FIFO.

---
 rtl/dec8b10b_wrap.sv | 260 ++++++++++++++++++++++++++
 tb/tb_dec8b10b_wrap.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/dec8b10b_wrap.sv
// Receive-side 8b/10b decoder: input sample, decode + running disparity, then comma lock
// and frame qualification before handing bytes and dataCode to the RX FIFO.
module dec8b10b_wrap #(
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_ERR = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] encDataIn,
   input  logic       encDataInrdy,
   output logic [7:0] dataOut,
   output logic [1:0] dataCode,
   output logic       dataOutrdy,
   output logic       code_err,
   output logic       disp_err,
   output logic       frame_err,
   output logic       locked
);
   localparam logic [1:0] CODE_DATA  = 2'b00;
   localparam logic [1:0] CODE_EOP   = 2'b01;
   localparam logic [1:0] CODE_SOP   = 2'b10;
   localparam logic [1:0] CODE_COMMA = 2'b11;
   localparam int CW = $clog2((LOCK_CNT > UNLOCK_ERR ? LOCK_CNT : UNLOCK_ERR) + 1);

   typedef enum logic {UNLOCKED, LOCKED}  lock_e;
   typedef enum logic {IDLE, IN_FRAME}    frame_e;

   // {valid, EDCBA}
   function automatic logic [5:0] dec6(input logic [5:0] s);
      case (s)
         6'b100111, 6'b011000: dec6 = {1'b1, 5'd0};
         6'b011101, 6'b100010: dec6 = {1'b1, 5'd1};
         6'b101101, 6'b010010: dec6 = {1'b1, 5'd2};
         6'b110001:            dec6 = {1'b1, 5'd3};
         6'b110101, 6'b001010: dec6 = {1'b1, 5'd4};
         6'b101001:            dec6 = {1'b1, 5'd5};
         6'b011001:            dec6 = {1'b1, 5'd6};
         6'b111000, 6'b000111: dec6 = {1'b1, 5'd7};
         6'b111001, 6'b000110: dec6 = {1'b1, 5'd8};
         6'b100101:            dec6 = {1'b1, 5'd9};
         6'b010101:            dec6 = {1'b1, 5'd10};
         6'b110100:            dec6 = {1'b1, 5'd11};
         6'b001101:            dec6 = {1'b1, 5'd12};
         6'b101100:            dec6 = {1'b1, 5'd13};
         6'b011100:            dec6 = {1'b1, 5'd14};
         6'b010111, 6'b101000: dec6 = {1'b1, 5'd15};
         6'b011011, 6'b100100: dec6 = {1'b1, 5'd16};
         6'b100011:            dec6 = {1'b1, 5'd17};
         6'b010011:            dec6 = {1'b1, 5'd18};
         6'b110010:            dec6 = {1'b1, 5'd19};
         6'b001011:            dec6 = {1'b1, 5'd20};
         6'b101010:            dec6 = {1'b1, 5'd21};
         6'b011010:            dec6 = {1'b1, 5'd22};
         6'b111010, 6'b000101: dec6 = {1'b1, 5'd23};
         6'b110011, 6'b001100: dec6 = {1'b1, 5'd24};
         6'b100110:            dec6 = {1'b1, 5'd25};
         6'b010110:            dec6 = {1'b1, 5'd26};
         6'b110110, 6'b001001: dec6 = {1'b1, 5'd27};
         6'b001110:            dec6 = {1'b1, 5'd28};
         6'b101110, 6'b010001: dec6 = {1'b1, 5'd29};
         6'b011110, 6'b100001: dec6 = {1'b1, 5'd30};
         6'b101011, 6'b010100: dec6 = {1'b1, 5'd31};
         6'b001111, 6'b110000: dec6 = {1'b1, 5'd28};
         default:              dec6 = 6'd0;
      endcase
   endfunction

   // {valid, HGF}
   function automatic logic [3:0] dec4(input logic [3:0] s);
      case (s)
         4'b1011, 4'b0100:                   dec4 = {1'b1, 3'd0};
         4'b1001:                            dec4 = {1'b1, 3'd1};
         4'b0101:                            dec4 = {1'b1, 3'd2};
         4'b1100, 4'b0011:                   dec4 = {1'b1, 3'd3};
         4'b1101, 4'b0010:                   dec4 = {1'b1, 3'd4};
         4'b1010:                            dec4 = {1'b1, 3'd5};
         4'b0110:                            dec4 = {1'b1, 3'd6};
         4'b1110, 4'b0001, 4'b0111, 4'b1000: dec4 = {1'b1, 3'd7};
         default:                            dec4 = 4'd0;
      endcase
   endfunction

   // reset asserts immediately, releases on the first edge after rst rises
   logic arst_n_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) arst_n_q <= 1'b0;
      else      arst_n_q <= 1'b1;

   logic [1:0] vld_pipe_q, vld_pipe_d;
   logic [9:0] sym_q;
   logic       rd_q, rd_d;
   logic [7:0] s1_byte_q, s1_byte_d;
   logic [1:0] s1_kind_q, s1_kind_d;
   logic       s1_cerr_q, s1_cerr_d, s1_derr_q, s1_derr_d;

   logic [5:0] s6, d6;
   logic [3:0] s4, s4_eff, d4;
   int         n6, n4, nt;
   logic       p6, m6, p4, m4, err6, err4, rd_mid, k28;

   always_comb begin
      vld_pipe_d = {vld_pipe_q[0], encDataInrdy};
      s6 = sym_q[9:4];
      s4 = sym_q[3:0];
      k28 = (s6 == 6'b001111) || (s6 == 6'b110000);
      // K28 under the RD+ prefix uses the complemented neutral fghj forms
      s4_eff = s4;
      if (s6 == 6'b110000 && (s4 == 4'b1001 || s4 == 4'b0110 || s4 == 4'b0101 || s4 == 4'b1010))
         s4_eff = ~s4;
      d6 = dec6(s6);
      d4 = dec4(s4_eff);
      n6 = $countones(s6);
      n4 = $countones(s4);
      nt = n6 + n4;
      p6 = (n6 == 4);
      m6 = (n6 == 2);
      p4 = (n4 == 3);
      m4 = (n4 == 1);
      err6   = rd_q ? (p6 || s6 == 6'b111000) : (m6 || s6 == 6'b000111);
      rd_mid = p6 ? 1'b1 : (m6 ? 1'b0 : rd_q);
      err4   = rd_mid ? (p4 || s4 == 4'b1100) : (m4 || s4 == 4'b0011);
      s1_byte_d = {d4[2:0], d6[4:0]};
      s1_kind_d = CODE_DATA;
      if (k28)
         s1_kind_d = (d4[2:0] == 3'd5) ? CODE_COMMA : ((d4[2:0] == 3'd1) ? CODE_SOP : CODE_EOP);
      // unbalanced-6b followed by the alternate 7 is a K.x.7, which is not accepted
      s1_cerr_d = !d6[5] || !d4[5-2] || nt < 4 || nt > 6
               || (k28 && !(d4[2:0] == 3'd1 || d4[2:0] == 3'd5 || d4[2:0] == 3'd6))
               || (!k28 && ((s4 == 4'b1000 && p6) || (s4 == 4'b0111 && m6)));
      s1_derr_d = !s1_cerr_d && (err6 || err4);
      rd_d = rd_q;
      if (vld_pipe_q[0] && !s1_cerr_d && nt != 5)
         rd_d = (nt == 6);
   end

   always_ff @(posedge clk or negedge arst_n_q)
      if (!arst_n_q) begin
         vld_pipe_q <= '0;
         sym_q      <= '0;
         rd_q       <= 1'b0;
         s1_byte_q  <= '0;
         s1_kind_q  <= CODE_DATA;
         s1_cerr_q  <= 1'b0;
         s1_derr_q  <= 1'b0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         if (encDataInrdy) sym_q <= encDataIn;
         rd_q <= rd_d;
         if (vld_pipe_q[0]) begin
            s1_byte_q <= s1_byte_d;
            s1_kind_q <= s1_kind_d;
            s1_cerr_q <= s1_cerr_d;
            s1_derr_q <= s1_derr_d;
         end
      end

   lock_e          lock_q, lock_d;
   frame_e         frame_q, frame_d;
   logic [CW-1:0]  comma_cnt_q, comma_cnt_d, err_cnt_q, err_cnt_d;
   logic [7:0]     data_out_q, data_out_d;
   logic [1:0]     data_code_q, data_code_d;
   logic           out_rdy_q, out_rdy_d, cerr_q, cerr_d, derr_q, derr_d, ferr_q, ferr_d;

   always_ff @(posedge clk or negedge arst_n_q)
      if (!arst_n_q) begin
         lock_q      <= UNLOCKED;
         frame_q     <= IDLE;
         comma_cnt_q <= '0;
         err_cnt_q   <= '0;
         data_out_q  <= '0;
         data_code_q <= CODE_DATA;
         out_rdy_q   <= 1'b0;
         cerr_q      <= 1'b0;
         derr_q      <= 1'b0;
         ferr_q      <= 1'b0;
      end else begin
         lock_q      <= lock_d;
         frame_q     <= frame_d;
         comma_cnt_q <= comma_cnt_d;
         err_cnt_q   <= err_cnt_d;
         data_out_q  <= data_out_d;
         data_code_q <= data_code_d;
         out_rdy_q   <= out_rdy_d;
         cerr_q      <= cerr_d;
         derr_q      <= derr_d;
         ferr_q      <= ferr_d;
      end

   always_comb begin
      lock_d      = lock_q;
      frame_d     = frame_q;
      comma_cnt_d = comma_cnt_q;
      err_cnt_d   = err_cnt_q;
      if (vld_pipe_q[1]) begin
         case (lock_q)
            UNLOCKED: begin
               if (s1_kind_q == CODE_COMMA && !s1_cerr_q && !s1_derr_q) begin
                  comma_cnt_d = (comma_cnt_q == {CW{1'b1}}) ? comma_cnt_q : comma_cnt_q + 1'b1;
                  if (comma_cnt_d == CW'(LOCK_CNT)) begin
                     lock_d      = LOCKED;
                     comma_cnt_d = '0;
                  end
               end else
                  comma_cnt_d = '0;
            end
            LOCKED: begin
               if (s1_cerr_q) begin
                  err_cnt_d = (err_cnt_q == {CW{1'b1}}) ? err_cnt_q : err_cnt_q + 1'b1;
                  if (err_cnt_d == CW'(UNLOCK_ERR)) begin
                     lock_d    = UNLOCKED;
                     err_cnt_d = '0;
                     frame_d   = IDLE;
                  end
               end else begin
                  err_cnt_d = '0;
                  if (s1_kind_q == CODE_SOP)
                     frame_d = IN_FRAME;
                  else if (s1_kind_q == CODE_EOP)
                     frame_d = IDLE;
               end
            end
            default: lock_d = UNLOCKED;
         endcase
      end
   end

   always_comb begin
      out_rdy_d   = 1'b0;
      ferr_d      = 1'b0;
      data_out_d  = data_out_q;
      data_code_d = data_code_q;
      cerr_d      = vld_pipe_q[1] && s1_cerr_q;
      derr_d      = vld_pipe_q[1] && s1_derr_q;
      if (vld_pipe_q[1] && lock_q == LOCKED && !s1_cerr_q) begin
         case (s1_kind_q)
            CODE_SOP: begin
               out_rdy_d = 1'b1;
               ferr_d    = (frame_q == IN_FRAME);
            end
            CODE_DATA, CODE_EOP: begin
               out_rdy_d = (frame_q == IN_FRAME);
               ferr_d    = (frame_q == IDLE);
            end
            default: ;
         endcase
      end
      if (out_rdy_d) begin
         data_out_d  = s1_byte_q;
         data_code_d = s1_kind_q;
      end
   end

   assign dataOut    = data_out_q;
   assign dataCode   = data_code_q;
   assign dataOutrdy = out_rdy_q;
   assign code_err   = cerr_q;
   assign disp_err   = derr_q;
   assign frame_err  = ferr_q;
   assign locked     = (lock_q == LOCKED);
endmodule

// File: tb/tb_dec8b10b_wrap.sv
// Directed bench for dec8b10b_wrap: lock, framing, disparity, unlock and mid-frame reset.
// Outputs seen after step k belong to the symbol driven two steps earlier.
module tb_dec8b10b_wrap;
   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] encDataIn;
   logic       encDataInrdy;
   logic [7:0] dataOut;
   logic [1:0] dataCode;
   logic       dataOutrdy, code_err, disp_err, frame_err, locked;

   int n_assert = 0;
   int n_fail   = 0;

   localparam logic [9:0] CM  = 10'b0011111010;  // K28.5 RD-
   localparam logic [9:0] CP  = 10'b1100000101;  // K28.5 RD+
   localparam logic [9:0] SM  = 10'b0011111001;  // K28.1 RD-
   localparam logic [9:0] SP  = 10'b1100000110;  // K28.1 RD+
   localparam logic [9:0] EP  = 10'b1100001001;  // K28.6 RD+
   localparam logic [9:0] D21 = 10'b1010101010;  // D21.5
   localparam logic [9:0] BAD = 10'b0000000000;

   dec8b10b_wrap #(.LOCK_CNT(4), .UNLOCK_ERR(4)) dut (
      .clk(clk), .rst(rst), .encDataIn(encDataIn), .encDataInrdy(encDataInrdy),
      .dataOut(dataOut), .dataCode(dataCode), .dataOutrdy(dataOutrdy),
      .code_err(code_err), .disp_err(disp_err), .frame_err(frame_err), .locked(locked)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic step(input logic [9:0] s, input logic v);
      encDataIn    = s;
      encDataInrdy = v;
      @(negedge clk);
   endtask

   task automatic idle();
      step(10'd0, 1'b0);
   endtask

   task automatic chk(input string tag, input logic rdy, input logic [1:0] code,
                      input logic [7:0] bv, input logic ce, input logic de,
                      input logic fe, input logic lk);
      logic [4:0] o, e;
      o = {dataOutrdy, code_err, disp_err, frame_err, locked};
      e = {rdy, ce, de, fe, lk};
      n_assert++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s flags{rdy,cerr,derr,ferr,lock}: observed %b expected %b", tag, o, e);
      end
      if (rdy) begin
         n_assert++;
         assert ({dataCode, dataOut} === {code, bv}) else begin
            n_fail++;
            $error("FAIL %s code/byte: observed %b/%h expected %b/%h", tag, dataCode, dataOut, code, bv);
         end
      end
   endtask

   task automatic chk_none(input string tag, input logic lk);
      chk(tag, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, lk);
   endtask

   task automatic chk_zero(input string tag);
      logic [14:0] o;
      o = {dataOut, dataCode, dataOutrdy, code_err, disp_err, frame_err, locked};
      n_assert++;
      assert (o === 15'd0) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected 0000", tag, o);
      end
   endtask

   initial begin
      rst = 1'b0;
      encDataIn = '0;
      encDataInrdy = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("reset_state");
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // lock: four alternating commas
      step(CM, 1);
      step(CP, 1);  chk_none("lock_pre", 0);
      step(CM, 1);  chk_none("lock_c1", 0);
      step(CP, 1);  chk_none("lock_c2", 0);
      idle();       chk_none("lock_c3", 0);
      idle();       chk_none("lock_c4", 1);

      // frame: SOP, 3x D21.5, EOP
      step(SM, 1);
      step(D21, 1); chk_none("frame_pre", 1);
      step(D21, 1); chk("frame_sop", 1, 2'b10, 8'h3C, 0, 0, 0, 1);
      step(D21, 1); chk("frame_d0", 1, 2'b00, 8'hB5, 0, 0, 0, 1);
      step(EP, 1);  chk("frame_d1", 1, 2'b00, 8'hB5, 0, 0, 0, 1);
      idle();       chk("frame_d2", 1, 2'b00, 8'hB5, 0, 0, 0, 1);
      idle();       chk("frame_eop", 1, 2'b01, 8'hDC, 0, 0, 0, 1);

      // disparity: RD+ comma while RD-, then clean RD- comma
      step(CP, 1);  chk_none("disp_pre0", 1);
      step(CM, 1);  chk_none("disp_pre1", 1);
      idle();       chk("disp_err", 0, 2'b00, 8'h00, 0, 1, 0, 1);
      idle();       chk_none("disp_clean", 1);

      // framing errors: data in IDLE, SOP then SOP, comma mid-frame
      step(D21, 1); chk_none("ferr_pre0", 1);
      step(SP, 1);  chk_none("ferr_pre1", 1);
      step(SM, 1);  chk("ferr_idle_data", 0, 2'b00, 8'h00, 0, 0, 1, 1);
      step(CP, 1);  chk("ferr_sop1", 1, 2'b10, 8'h3C, 0, 0, 0, 1);
      step(D21, 1); chk("ferr_sop2", 1, 2'b10, 8'h3C, 0, 0, 1, 1);
      idle();       chk_none("ferr_comma", 1);
      idle();       chk("ferr_data_after_comma", 1, 2'b00, 8'hB5, 0, 0, 0, 1);

      // code errors and unlock, then SOP/data/EOP suppressed
      step(BAD, 1); chk_none("unl_pre0", 1);
      step(BAD, 1); chk_none("unl_pre1", 1);
      step(BAD, 1); chk("unl_e1", 0, 2'b00, 8'h00, 1, 0, 0, 1);
      step(BAD, 1); chk("unl_e2", 0, 2'b00, 8'h00, 1, 0, 0, 1);
      step(SM, 1);  chk("unl_e3", 0, 2'b00, 8'h00, 1, 0, 0, 1);
      step(D21, 1); chk("unl_e4", 0, 2'b00, 8'h00, 1, 0, 0, 0);
      step(EP, 1);  chk_none("unl_sop", 0);
      idle();       chk_none("unl_data", 0);
      idle();       chk_none("unl_eop", 0);

      // re-lock and start a frame, then reset mid-frame
      step(CM, 1);
      step(CP, 1);
      step(CM, 1);
      step(CP, 1);
      idle();       chk_none("relock_c3", 0);
      idle();       chk_none("relock_c4", 1);
      step(SM, 1);
      step(D21, 1);
      idle();       chk("mid_sop", 1, 2'b10, 8'h3C, 0, 0, 0, 1);
      idle();       chk("mid_data", 1, 2'b00, 8'hB5, 0, 0, 0, 1);
      #2 rst = 1'b0;
      #1 chk_zero("reset_midframe");
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      step(D21, 1);
      idle();
      idle();       chk_none("post_reset_drop", 0);

      step(CM, 1);
      step(CP, 1);
      step(CM, 1);
      step(CP, 1);
      idle();       chk_none("post_reset_c3", 0);
      idle();       chk_none("post_reset_c4", 1);
      step(SM, 1);
      step(D21, 1);
      idle();       chk("post_reset_sop", 1, 2'b10, 8'h3C, 0, 0, 0, 1);
      idle();       chk("post_reset_data", 1, 2'b00, 8'hB5, 0, 0, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
